// File: rtl/jtag_scan_master_if.sv
// Command/result handshake and JTAG pin bundle for jtag_scan_master.
// master: host plus scan-chain side; slave: the scan master itself.
interface jtag_scan_master_if #(
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = 6
);
   logic               start;
   logic               is_ir;
   logic [LEN_W-1:0]   len;
   logic [MAX_LEN-1:0] data_in;
   logic               busy;
   logic               done;
   logic [MAX_LEN-1:0] data_out;
   logic               TMS;
   logic               TDI;
   logic               TDO;

   modport master (
      output start, is_ir, len, data_in, TDO,
      input  busy, done, data_out, TMS, TDI
   );

   modport slave (
      input  start, is_ir, len, data_in, TDO,
      output busy, done, data_out, TMS, TDI
   );
endinterface

// File: rtl/jtag_scan_master.sv
// Host-side JTAG scan master: Test-Logic-Reset walk after reset, then one IR/DR scan per start.
// Optional Run-Test/Idle hold after Update is enabled by defining JSM_RTI_HOLD_EN.
module jtag_scan_master #(
   parameter int MAX_LEN    = 32,
   parameter int LEN_W      = 6,
   parameter int RTI_CYCLES = 4
) (
   input logic               TCK,
   input logic               RST,
   jtag_scan_master_if.slave bus
);

   if (MAX_LEN < 2 || LEN_W < 3 || (64'd1 << LEN_W) <= 64'(MAX_LEN) || RTI_CYCLES < 0) begin : g_bad_params
      $error("jtag_scan_master: unsupported parameter set");
   end

`ifdef JSM_RTI_HOLD_EN
   localparam int HOLD_W = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;

   if (RTI_CYCLES < 1) begin : g_bad_hold
      $error("jtag_scan_master: RTI_CYCLES must be at least 1");
   end
`endif

   // Each state names the TAP state during that TCK cycle.
   typedef enum logic [3:0] {
      TLR_SEQ  = 4'd0,
      RST_RTI  = 4'd1,
      IDLE     = 4'd2,
      LAUNCH   = 4'd3,
      SEL_DR   = 4'd4,
      SEL_IR   = 4'd5,
      CAPTURE  = 4'd6,
      SHIFT    = 4'd7,
      EXIT1    = 4'd8,
      UPDATE   = 4'd9
`ifdef JSM_RTI_HOLD_EN
      ,
      RTI_HOLD = 4'd10
`endif
   } state_t;

   state_t             state_r;
   logic [LEN_W-1:0]   cnt_r;
   logic [LEN_W-1:0]   len_r;
   logic               is_ir_r;
   logic [MAX_LEN-1:0] sh_r;
   logic [MAX_LEN-1:0] data_out_r;
   logic               tms_r;
   logic               tdi_r;
   logic               busy_r;
   logic               done_r;
`ifdef JSM_RTI_HOLD_EN
   logic [HOLD_W-1:0]  hold_cnt_r;
`endif

   logic [LEN_W-1:0]   len_clamped_s;
   logic               accept_s;
   logic               last_bit_s;
   logic               next_last_s;

   // Clamp the requested length and flag the final / penultimate shift bit.
   always_comb begin
      len_clamped_s = bus.len;
      if (bus.len > LEN_W'(MAX_LEN)) begin
         len_clamped_s = LEN_W'(MAX_LEN);
      end else begin
         len_clamped_s = bus.len;
      end
      accept_s    = bus.start && (bus.len != {LEN_W{1'b0}});
      last_bit_s  = (cnt_r == (len_r - LEN_W'(1)));
      next_last_s = (cnt_r == (len_r - LEN_W'(2)));
   end

   // Scan sequencer; TMS/TDI are loaded with the value for the state being entered.
   always_ff @(posedge TCK or posedge RST) begin
      if (RST) begin
         state_r    <= TLR_SEQ;
         cnt_r      <= {LEN_W{1'b0}};
         len_r      <= {LEN_W{1'b0}};
         is_ir_r    <= 1'b0;
         sh_r       <= {MAX_LEN{1'b0}};
         data_out_r <= {MAX_LEN{1'b0}};
         tms_r      <= 1'b1;
         tdi_r      <= 1'b0;
         busy_r     <= 1'b1;
         done_r     <= 1'b0;
`ifdef JSM_RTI_HOLD_EN
         hold_cnt_r <= {HOLD_W{1'b0}};
`endif
      end else begin
         done_r <= 1'b0;
         tdi_r  <= 1'b0;
         case (state_r)
            TLR_SEQ: begin
               // Five TMS=1 cycles reach Test-Logic-Reset from any TAP state.
               if (cnt_r == LEN_W'(4)) begin
                  state_r <= RST_RTI;
                  cnt_r   <= {LEN_W{1'b0}};
                  tms_r   <= 1'b0;
               end else begin
                  cnt_r   <= cnt_r + LEN_W'(1);
                  tms_r   <= 1'b1;
               end
            end
            RST_RTI: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               tms_r   <= 1'b0;
            end
            IDLE: begin
               if (accept_s) begin
                  state_r    <= LAUNCH;
                  is_ir_r    <= bus.is_ir;
                  len_r      <= len_clamped_s;
                  sh_r       <= bus.data_in;
                  data_out_r <= {MAX_LEN{1'b0}};
                  cnt_r      <= {LEN_W{1'b0}};
                  busy_r     <= 1'b1;
                  tms_r      <= 1'b1;
               end else begin
                  busy_r     <= 1'b0;
                  tms_r      <= 1'b0;
               end
            end
            LAUNCH: begin
               state_r <= SEL_DR;
               tms_r   <= is_ir_r;
            end
            SEL_DR: begin
               if (is_ir_r) begin
                  state_r <= SEL_IR;
               end else begin
                  state_r <= CAPTURE;
               end
               tms_r <= 1'b0;
            end
            SEL_IR: begin
               state_r <= CAPTURE;
               tms_r   <= 1'b0;
            end
            CAPTURE: begin
               state_r <= SHIFT;
               cnt_r   <= {LEN_W{1'b0}};
               tms_r   <= (len_r == LEN_W'(1));
               tdi_r   <= sh_r[0];
            end
            SHIFT: begin
               data_out_r <= data_out_r | (MAX_LEN'(bus.TDO) << cnt_r);
               if (last_bit_s) begin
                  state_r <= EXIT1;
                  tms_r   <= 1'b1;
               end else begin
                  cnt_r   <= cnt_r + LEN_W'(1);
                  sh_r    <= sh_r >> 1;
                  tdi_r   <= sh_r[1];
                  tms_r   <= next_last_s;
               end
            end
            EXIT1: begin
               state_r <= UPDATE;
               tms_r   <= 1'b0;
            end
            UPDATE: begin
`ifdef JSM_RTI_HOLD_EN
               state_r    <= RTI_HOLD;
               hold_cnt_r <= {HOLD_W{1'b0}};
               tms_r      <= 1'b0;
`else
               state_r    <= IDLE;
               done_r     <= 1'b1;
               busy_r     <= 1'b0;
               tms_r      <= 1'b0;
`endif
            end
`ifdef JSM_RTI_HOLD_EN
            RTI_HOLD: begin
               if (hold_cnt_r == HOLD_W'(RTI_CYCLES - 1)) begin
                  state_r    <= IDLE;
                  done_r     <= 1'b1;
                  busy_r     <= 1'b0;
               end else begin
                  hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
               end
               tms_r <= 1'b0;
            end
`endif
            default: begin
               state_r <= TLR_SEQ;
               cnt_r   <= {LEN_W{1'b0}};
               busy_r  <= 1'b1;
               tms_r   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.TMS      = tms_r;
   assign bus.TDI      = tdi_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.data_out = data_out_r;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master: a TAP state model follows TMS and drives TDO
// from a capture/shift chain; scans are checked against hand-computed vectors.
module tb_jtag_scan_master;
   localparam int MAX_LEN = 32;
   localparam int LEN_W   = 6;
   localparam int RTI     = 4;
`ifdef JSM_RTI_HOLD_EN
   localparam int EXTRA = RTI;
`else
   localparam int EXTRA = 0;
`endif

   logic TCK = 1'b0;
   logic RST = 1'b1;

   jtag_scan_master_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

   jtag_scan_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .RTI_CYCLES(RTI)) dut (
      .TCK (TCK),
      .RST (RST),
      .bus (bus)
   );

   always #5 TCK = ~TCK;

   typedef enum logic [3:0] {
      T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PSDR, T_EX2DR,
      T_UPDDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PSIR, T_EX2IR, T_UPDIR
   } tap_t;

   function automatic tap_t tap_next(input tap_t s, input logic m);
      case (s)
         T_TLR:   return m ? T_TLR   : T_RTI;
         T_RTI:   return m ? T_SELDR : T_RTI;
         T_SELDR: return m ? T_SELIR : T_CAPDR;
         T_CAPDR: return m ? T_EX1DR : T_SHDR;
         T_SHDR:  return m ? T_EX1DR : T_SHDR;
         T_EX1DR: return m ? T_UPDDR : T_PSDR;
         T_PSDR:  return m ? T_EX2DR : T_PSDR;
         T_EX2DR: return m ? T_UPDDR : T_SHDR;
         T_UPDDR: return m ? T_SELDR : T_RTI;
         T_SELIR: return m ? T_TLR   : T_CAPIR;
         T_CAPIR: return m ? T_EX1IR : T_SHIR;
         T_SHIR:  return m ? T_EX1IR : T_SHIR;
         T_EX1IR: return m ? T_UPDIR : T_PSIR;
         T_PSIR:  return m ? T_EX2IR : T_PSIR;
         T_EX2IR: return m ? T_UPDIR : T_SHIR;
         T_UPDIR: return m ? T_SELDR : T_RTI;
         default: return T_TLR;
      endcase
   endfunction

   tap_t        tap      = T_TLR;
   logic        tms_q    = 1'b1;
   logic        tdi_q    = 1'b0;
   logic        busy_q   = 1'b1;
   logic [63:0] chain    = 64'd0;
   logic [63:0] dr_cap   = 64'd0;
   logic [63:0] ir_cap   = 64'd0;
   logic [63:0] tms_vec  = 64'd0;
   logic [63:0] busy_vec = 64'd0;
   logic [63:0] tdi_vec  = 64'd0;
   int          n_shift  = 0;
   int          tdi_bad  = 0;
   int          done_cnt = 0;
   int          total    = 0;
   int          passed   = 0;

   // Target side: sample the master mid-cycle and present TDO on the falling edge.
   always @(negedge TCK) begin
      tms_q   <= bus.TMS;
      tdi_q   <= bus.TDI;
      busy_q  <= bus.busy;
      bus.TDO <= chain[0];
      if (bus.done) done_cnt <= done_cnt + 1;
   end

   // TAP model: advance on TMS, capture/shift the chain, log newest entry at bit 63.
   always @(posedge TCK) begin
      tap      <= tap_next(tap, tms_q);
      tms_vec  <= {tms_q, tms_vec[63:1]};
      busy_vec <= {busy_q, busy_vec[63:1]};
      if (tap == T_CAPDR) begin
         chain <= dr_cap;
      end else if (tap == T_CAPIR) begin
         chain <= ir_cap;
      end else if (tap == T_SHDR || tap == T_SHIR) begin
         chain   <= {tdi_q, chain[63:1]};
         tdi_vec <= {tdi_q, tdi_vec[63:1]};
         n_shift <= n_shift + 1;
      end
      if (tdi_q && !(tap == T_SHDR || tap == T_SHIR)) tdi_bad <= tdi_bad + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge TCK);
      #1;
   endtask

   task automatic check_reset_seq(input string tag);
      int b_bad;
      int b_done;
      b_bad  = tdi_bad;
      b_done = done_cnt;
      RST = 1'b0;
      repeat (7) tick();
      chk({tag, " tms seq"},  tms_vec >> 57, 64'h1F);
      chk({tag, " busy seq"}, busy_vec >> 57, 64'h3F);
      chk({tag, " tap rti"},  64'(tap), 64'(T_RTI));
      chk({tag, " tdi quiet"}, 64'(tdi_bad - b_bad), 64'd0);
      chk({tag, " no done"},  64'(done_cnt - b_done), 64'd0);
   endtask

   task automatic run_scan(input string tag, input logic ir, input logic [LEN_W-1:0] l,
                           input logic [31:0] din, input logic [63:0] cap, input int exp_lat,
                           input int exp_bits, input logic [63:0] exp_tms,
                           input logic [31:0] exp_tdi, input logic [31:0] exp_dout, input logic poke);
      int b_shift;
      int b_bad;
      int lat;
      logic got;
      if (ir) ir_cap = cap;
      else    dr_cap = cap;
      bus.is_ir   = ir;
      bus.len     = l;
      bus.data_in = din;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      b_shift = n_shift;
      b_bad   = tdi_bad;
      lat     = 0;
      got     = 1'b0;
      while (!got && lat < 200) begin
         if (poke && lat == 3) begin
            bus.start = 1'b1;
            bus.len   = 6'd3;
            bus.is_ir = ~ir;
         end
         if (poke && lat == 5) bus.start = 1'b0;
         tick();
         lat++;
         if (lat == 2) chk({tag, " busy mid"}, 64'(bus.busy), 64'd1);
         got = bus.done;
      end
      chk({tag, " latency"},  64'(lat), 64'(exp_lat));
      chk({tag, " tms seq"},  tms_vec >> (64 - lat), exp_tms);
      chk({tag, " shifts"},   64'(n_shift - b_shift), 64'(exp_bits));
      chk({tag, " tdi seq"},  tdi_vec >> (64 - exp_bits), 64'(exp_tdi));
      chk({tag, " data_out"}, 64'(bus.data_out), 64'(exp_dout));
      chk({tag, " busy low"}, 64'(bus.busy), 64'd0);
      chk({tag, " tdi quiet"}, 64'(tdi_bad - b_bad), 64'd0);
   endtask

   initial begin
      int d0;
      int b_shift;
      int k;
      bus.start   = 1'b0;
      bus.is_ir   = 1'b0;
      bus.len     = 6'd0;
      bus.data_in = 32'd0;

      repeat (2) tick();
      chk("rst tms",      64'(bus.TMS), 64'd1);
      chk("rst tdi",      64'(bus.TDI), 64'd0);
      chk("rst busy",     64'(bus.busy), 64'd1);
      chk("rst done",     64'(bus.done), 64'd0);
      chk("rst data_out", 64'(bus.data_out), 64'd0);
      check_reset_seq("por");

      // len=40 clamps to 32 shifts: last-bit TMS at entry 34, Exit1 at 35.
      run_scan("clamp", 1'b0, 6'd40, 32'hDEAD_BEEF, 64'h0000_0001_CAFE_F00D, 37 + EXTRA, 32,
               64'h0000_000C_0000_0001, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
      repeat (3) tick();

      d0 = done_cnt;
      run_scan("dr4", 1'b0, 6'd4, 32'h0000_000B, 64'h6, 9 + EXTRA, 4,
               64'h0C1, 32'hB, 32'h0000_0006, 1'b0);
      repeat (3) tick();
      chk("dr4 one done", 64'(done_cnt - d0), 64'd1);

      d0 = done_cnt;
      run_scan("ir1", 1'b1, 6'd1, 32'h1, 64'h1, 7 + EXTRA, 1,
               64'h33, 32'h1, 32'h1, 1'b0);
      run_scan("dr8 b2b", 1'b0, 6'd8, 32'h0000_00A5, 64'h3C, 13 + EXTRA, 8,
               64'hC01, 32'hA5, 32'h0000_003C, 1'b1);
      repeat (3) tick();
      chk("poke not queued", 64'(bus.busy), 64'd0);
      chk("two dones",       64'(done_cnt - d0), 64'd2);
      chk("data_out held",   64'(bus.data_out), 64'h3C);

      bus.len   = 6'd0;
      bus.start = 1'b1;
      repeat (2) tick();
      bus.start = 1'b0;
      chk("len0 busy", 64'(bus.busy), 64'd0);
      chk("len0 tms",  64'(bus.TMS), 64'd0);
      chk("len0 tap",  64'(tap), 64'(T_RTI));

      // Reset during bit 2 of an 8-bit DR scan.
      dr_cap      = 64'hFF;
      bus.is_ir   = 1'b0;
      bus.len     = 6'd8;
      bus.data_in = 32'h0000_00FF;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      b_shift = n_shift;
      k = 0;
      while ((n_shift - b_shift) != 2 && k < 50) begin
         tick();
         k++;
      end
      chk("rst mid at bit2", 64'(n_shift - b_shift), 64'd2);
      d0 = done_cnt;
      RST = 1'b1;
      #1;
      chk("rst mid tms",      64'(bus.TMS), 64'd1);
      chk("rst mid busy",     64'(bus.busy), 64'd1);
      chk("rst mid data_out", 64'(bus.data_out), 64'd0);
      repeat (2) tick();
      check_reset_seq("rst mid");
      chk("rst mid no done", 64'(done_cnt - d0), 64'd0);

      run_scan("dr4 again", 1'b0, 6'd4, 32'h0000_000B, 64'h6, 9 + EXTRA, 4,
               64'h0C1, 32'hB, 32'h0000_0006, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Host-side JTAG driver: the initiator that generates TMS/TDI for the TAP controller and the chain of boundary-scan cells, and samples TDO.
- Accepts one IR- or DR-scan command (length, shift data) and walks the TAP from Run-Test/Idle through Capture, Shift, Exit1 and Update, then back to Run-Test/Idle.
- Returns the captured TDO bits.
- Runs on the same TCK that clocks the TAP and the boundary-scan cells.

Parameters:
- MAX_LEN, 32, maximum scan length in bits (width of data_in/data_out).
- LEN_W, 6, width of the len port; must hold MAX_LEN.
- RTI_CYCLES, 4, extra Run-Test/Idle cycles after Update (used only with the optional feature).

Ports:
- TCK  input  1  scan clock; all state updates on posedge TCK.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  command request; sampled only while busy=0.
- is_ir  input  1  1 = IR scan, 0 = DR scan; captured with start.
- len  input  LEN_W  number of bits to shift; captured with start.
- data_in  input  MAX_LEN  shift data, bit 0 is shifted first; captured with start.
- TDO  input  1  serial data from the scan chain; target changes it on negedge TCK.
- TMS  output  1  mode select to the TAP.
- TDI  output  1  serial data to the scan chain.
- busy  output  1  high while a reset sequence or scan is in progress.
- done  output  1  one-cycle pulse when a scan completes.
- data_out  output  MAX_LEN  captured TDO bits, bit 0 is the first bit sampled.

Behaviour:
- Timing convention: the master's state names the TAP state during that TCK cycle. TMS/TDI are driven throughout the cycle and sampled by the TAP at its closing posedge. TMS/TDI are decoded from registered state/counter only; there is no combinational path from start.
- Reset (RST=1, asynchronous): state=TLR_SEQ, bit counter=0, TMS=1, TDI=0, busy=1, done=0, data_out=0. Registered command fields clear to 0.
- After RST falls:
  - 5 cycles with TMS=1 (guarantees Test-Logic-Reset).
  - 1 cycle with TMS=0 (TAP enters Run-Test/Idle).
  - Then IDLE, busy=0.
- RST asserted mid-scan: the scan is abandoned immediately, no done pulse, and the full reset sequence runs again.
- IDLE: TMS=0, TDI=0. On posedge with start=1, the block latches is_ir, len and data_in, sets busy=1 and goes to LAUNCH.
- len handling:
  - len=0: start is ignored; busy stays 0.
  - len>MAX_LEN: clamped to MAX_LEN.
- State sequence and TMS per state:
  - LAUNCH (TAP in RTI): TMS=1.
  - SEL_DR: TMS=is_ir.
  - SEL_IR (IR scans only): TMS=0.
  - CAPTURE: TMS=0.
  - SHIFT for exactly len cycles: TMS=0, except TMS=1 on the final bit.
  - EXIT1: TMS=1.
  - UPDATE: TMS=0, then IDLE.
- Shift data: in SHIFT cycle i (i=0..len-1), TDI=data_in_latched[i]. At the closing posedge of that cycle, TDO is stored into data_out[i]. data_out bits at index len and above are cleared at start.
- TDI=0 in every state other than SHIFT.
- done: pulses high for one cycle on the first IDLE cycle after UPDATE. busy falls in the same cycle. data_out is stable from done until the next accepted start.
- Latency from the start posedge to the done cycle: DR scan = len+5 cycles; IR scan = len+6 cycles.
- start while busy=1: ignored, never queued.
- start asserted in the done cycle: accepted, giving back-to-back scans with no extra idle cycle.

Optional Feature:
- Macro: JSM_RTI_HOLD_EN.
- Defined: after UPDATE the block enters RTI_HOLD with TMS=0 for RTI_CYCLES cycles. busy stays 1 during RTI_HOLD; done and busy fall on the following IDLE cycle. Latency increases by RTI_CYCLES.
- Undefined: RTI_HOLD does not exist, RTI_CYCLES is unused, and timing is exactly as stated above.

Test Plan:
- Reset release → TMS=1 for 5 cycles, then TMS=0 for 1 cycle; busy=1 throughout, then busy=0; TDI=0 throughout.
- DR scan, len=4, data_in=4'b1011, TDO driven by a 4-bit model preloaded with 4'b0110 → TMS sequence 1,0,0,0,0,0,1,1,0; TDI during SHIFT 1,1,0,1; data_out=4'b0110; done after 9 cycles.
- IR scan, len=1, data_in=1 → TMS sequence 1,1,0,0,1,1,0; single SHIFT cycle with TDI=1 and TMS=1; done after 7 cycles.
- start pulsed mid-scan and start with len=0 → both ignored. len=40 with MAX_LEN=32 → exactly 32 SHIFT cycles.
- RST asserted during SHIFT bit 2 of an 8-bit scan → TMS=1 immediately, no done pulse, full reset sequence, then busy=0.
- JSM_RTI_HOLD_EN defined, RTI_CYCLES=4, DR len=4 → 4 TMS=0 cycles after UPDATE; done after 13 cycles.
